// File: rtl/apb_master_arbiter_if.sv
// Bundle for the two requester ports and the APB master port of apb_master_arbiter.
// master modport is the arbiter's view; slave modport is the requester/APB-target side.
interface apb_master_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [1:0]              req_valid_i;
    logic [1:0]              req_write_i;
    logic [2*ADDR_WIDTH-1:0] req_addr_i;
    logic [2*DATA_WIDTH-1:0] req_wdata_i;
    logic [1:0]              req_done_o;
    logic [DATA_WIDTH-1:0]   rdata_o;
    logic                    err_o;
    logic [ADDR_WIDTH-1:0]   paddr_o;
    logic                    pwrite_o;
    logic                    psel_o;
    logic                    penable_o;
    logic [DATA_WIDTH-1:0]   pwdata_o;
    logic [DATA_WIDTH-1:0]   prdata_i;
    logic                    pready_i;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, prdata_i, pready_i,
        output req_done_o, rdata_o, err_o, paddr_o, pwrite_o, psel_o, penable_o, pwdata_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, prdata_i, pready_i,
        input  req_done_o, rdata_o, err_o, paddr_o, pwrite_o, psel_o, penable_o, pwdata_o
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB master (IDLE/SETUP/ACCESS) with registered outputs.
// Optional ACCESS-phase timeout abort is compiled in with `define APB_TIMEOUT_EN.
module apb_master_arbiter #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk_i,
    input  logic                    preset_i,
    apb_master_arbiter_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_r, state_nx;
    logic                  last_grant_r, last_grant_nx;
    logic                  grant_r, grant_nx;
    logic                  psel_r, psel_nx;
    logic                  penable_r, penable_nx;
    logic                  pwrite_r, pwrite_nx;
    logic [ADDR_WIDTH-1:0] paddr_r, paddr_nx;
    logic [DATA_WIDTH-1:0] pwdata_r, pwdata_nx;
    logic [DATA_WIDTH-1:0] rdata_r, rdata_nx;
    logic [1:0]            done_r, done_nx;
    logic                  err_r, err_nx;
    logic [1:0]            eligible;
    logic                  win;
    logic                  timeout;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_r;

    // Held at zero outside ACCESS, so it is already clear on the first ACCESS cycle.
    always_ff @(posedge pclk_i) begin
        if (preset_i || state_r != ACCESS) begin
            wait_cnt_r <= '0;
        end else if (!bus.pready_i) begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
        end
    end

    assign timeout = (state_r == ACCESS) && !bus.pready_i &&
                     (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            grant_r      <= 1'b0;
            psel_r       <= 1'b0;
            penable_r    <= 1'b0;
            pwrite_r     <= 1'b0;
            paddr_r      <= '0;
            pwdata_r     <= '0;
            rdata_r      <= '0;
            done_r       <= '0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_nx;
            last_grant_r <= last_grant_nx;
            grant_r      <= grant_nx;
            psel_r       <= psel_nx;
            penable_r    <= penable_nx;
            pwrite_r     <= pwrite_nx;
            paddr_r      <= paddr_nx;
            pwdata_r     <= pwdata_nx;
            rdata_r      <= rdata_nx;
            done_r       <= done_nx;
            err_r        <= err_nx;
        end
    end

    always_comb begin
        state_nx      = state_r;
        last_grant_nx = last_grant_r;
        grant_nx      = grant_r;
        psel_nx       = psel_r;
        penable_nx    = penable_r;
        pwrite_nx     = pwrite_r;
        paddr_nx      = paddr_r;
        pwdata_nx     = pwdata_r;
        rdata_nx      = rdata_r;
        done_nx       = 2'b00;
        err_nx        = 1'b0;
        // A requester whose done is pulsing this cycle still shows its old valid; ignore it.
        eligible      = bus.req_valid_i & ~done_r;
        win           = (eligible == 2'b11) ? ~last_grant_r : eligible[1];

        unique case (state_r)
            IDLE: begin
                psel_nx    = 1'b0;
                penable_nx = 1'b0;
                if (eligible != 2'b00) begin
                    grant_nx  = win;
                    pwrite_nx = win ? bus.req_write_i[1] : bus.req_write_i[0];
                    paddr_nx  = win ? bus.req_addr_i[ADDR_WIDTH +: ADDR_WIDTH]
                                    : bus.req_addr_i[0 +: ADDR_WIDTH];
                    pwdata_nx = win ? bus.req_wdata_i[DATA_WIDTH +: DATA_WIDTH]
                                    : bus.req_wdata_i[0 +: DATA_WIDTH];
                    psel_nx   = 1'b1;
                    state_nx  = SETUP;
                end
            end
            SETUP: begin
                penable_nx = 1'b1;
                state_nx   = ACCESS;
            end
            ACCESS: begin
                if (bus.pready_i) begin
                    psel_nx       = 1'b0;
                    penable_nx    = 1'b0;
                    done_nx       = grant_r ? 2'b10 : 2'b01;
                    last_grant_nx = grant_r;
                    if (!pwrite_r) begin
                        rdata_nx = bus.prdata_i;
                    end
                    state_nx      = IDLE;
                end else if (timeout) begin
                    psel_nx       = 1'b0;
                    penable_nx    = 1'b0;
                    done_nx       = grant_r ? 2'b10 : 2'b01;
                    err_nx        = 1'b1;
                    rdata_nx      = '0;
                    last_grant_nx = grant_r;
                    state_nx      = IDLE;
                end
            end
            default: begin
                psel_nx    = 1'b0;
                penable_nx = 1'b0;
                state_nx   = IDLE;
            end
        endcase
    end

    assign bus.req_done_o = done_r;
    assign bus.rdata_o    = rdata_r;
    assign bus.err_o      = err_r;
    assign bus.paddr_o    = paddr_r;
    assign bus.pwrite_o   = pwrite_r;
    assign bus.psel_o     = psel_r;
    assign bus.penable_o  = penable_r;
    assign bus.pwdata_o   = pwdata_r;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed cases plus randomized traffic checked against
// a transaction-level arbitration/APB-target model.
module tb_apb_master_arbiter;

    logic pclk_i   = 1'b0;
    logic preset_i = 1'b1;
    always #5 pclk_i = ~pclk_i;

    apb_master_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    apb_master_arbiter #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk_i   (pclk_i),
        .preset_i (preset_i),
        .bus      (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mem [256];
    logic [7:0] rdata_m;
    logic       last_m, cur_g, cur_wr;
    logic [7:0] cur_addr, cur_wdata;
    logic [1:0] s_v, s_wr, s_done, elig, exp_done;
    logic [15:0] s_addr, s_wdata;
    logic       s_psel, s_pen, s_ready;
    int         gi, waits_left;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk_i);
        #1;
    endtask

    task automatic set_req(input int r, input logic wr, input logic [7:0] a, input logic [7:0] d);
        bus.req_write_i[r]         = wr;
        bus.req_addr_i[r*8 +: 8]   = a;
        bus.req_wdata_i[r*8 +: 8]  = d;
        bus.req_valid_i[r]         = 1'b1;
    endtask

    task automatic new_fields(input int r);
        bus.req_write_i[r]        = 1'($urandom_range(0, 1));
        bus.req_addr_i[r*8 +: 8]  = 8'($urandom);
        bus.req_wdata_i[r*8 +: 8] = 8'($urandom);
    endtask

    // One isolated transfer with a given number of wait states, checked cycle by cycle.
    task automatic xfer(input int r, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input int waits, input logic [7:0] rd);
        set_req(r, wr, a, d);
        bus.pready_i = 1'b0;
        tick;
        check_eq("x_setup", 32'({bus.psel_o, bus.penable_o}), 32'(2'b10));
        check_eq("x_paddr", 32'(bus.paddr_o), 32'(a));
        check_eq("x_pwrite", 32'(bus.pwrite_o), 32'(wr));
        if (wr) check_eq("x_pwdata", 32'(bus.pwdata_o), 32'(d));
        bus.req_valid_i[r]       = 1'b0;
        bus.req_addr_i[r*8 +: 8] = ~a;
        bus.req_write_i[r]       = ~wr;
        tick;
        check_eq("x_access", 32'({bus.psel_o, bus.penable_o, bus.paddr_o}), 32'({2'b11, a}));
        for (int w = 0; w < waits; w++) begin
            bus.pready_i = 1'b0;
            bus.prdata_i = 8'hEE;
            tick;
            check_eq("x_wait", 32'({bus.psel_o, bus.penable_o, bus.req_done_o}), 32'(4'b1100));
        end
        bus.pready_i = 1'b1;
        bus.prdata_i = rd;
        tick;
        if (!wr) rdata_m = rd;
        check_eq("x_end", 32'({bus.psel_o, bus.penable_o}), 32'(0));
        check_eq("x_done", 32'(bus.req_done_o), (r == 1) ? 32'(2) : 32'(1));
        check_eq("x_err", 32'(bus.err_o), 32'(0));
        check_eq("x_rdata", 32'(bus.rdata_o), 32'(rdata_m));
        bus.pready_i = 1'b0;
        tick;
        check_eq("x_done_clr", 32'(bus.req_done_o), 32'(0));
    endtask

    initial begin
        bus.req_valid_i = '0;
        bus.req_write_i = '0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.prdata_i    = '0;
        bus.pready_i    = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        // Reset state
        preset_i = 1'b1;
        tick;
        tick;
        check_eq("rst_ctl", 32'({bus.psel_o, bus.penable_o, bus.req_done_o, bus.err_o}), 32'(0));
        check_eq("rst_data", 32'({bus.paddr_o, bus.pwdata_o, bus.rdata_o, bus.pwrite_o}), 32'(0));
        preset_i = 1'b0;
        rdata_m  = 8'h00;

        // Zero-wait write from requester 0, then 2-wait read from requester 1
        xfer(0, 1'b1, 8'h10, 8'hA5, 0, 8'h00);
        xfer(1, 1'b0, 8'h04, 8'h00, 2, 8'h3C);

        // Both requesters continuously valid from reset: 0,1,0,1,0 on a 3-cycle period
        preset_i     = 1'b1;
        set_req(0, 1'b1, 8'h20, 8'h11);
        set_req(1, 1'b1, 8'h30, 8'h22);
        bus.pready_i = 1'b1;
        tick;
        preset_i = 1'b0;
        rdata_m  = 8'h00;
        check_eq("rr_rst", 32'(bus.psel_o), 32'(0));
        for (int i = 0; i < 5; i++) begin
            tick;
            check_eq("rr_grant", 32'({bus.psel_o, bus.penable_o, bus.paddr_o}),
                     32'({2'b10, ((i % 2) == 1) ? 8'h30 : 8'h20}));
            tick;
            tick;
            check_eq("rr_done", 32'(bus.req_done_o), ((i % 2) == 1) ? 32'(2) : 32'(1));
        end
        bus.req_valid_i = 2'b00;
        tick;
        check_eq("rr_idle", 32'(bus.psel_o), 32'(0));

        // Reset during ACCESS; afterwards a tie goes to requester 0 again
        set_req(0, 1'b1, 8'h40, 8'h33);
        bus.pready_i = 1'b0;
        tick;
        bus.req_valid_i = 2'b00;
        tick;
        tick;
        preset_i = 1'b1;
        tick;
        preset_i = 1'b0;
        check_eq("mid_rst", 32'({bus.psel_o, bus.penable_o, bus.req_done_o, bus.err_o}), 32'(0));
        set_req(0, 1'b1, 8'h50, 8'h44);
        set_req(1, 1'b1, 8'h60, 8'h55);
        bus.pready_i = 1'b1;
        tick;
        check_eq("mid_rst_tie", 32'(bus.paddr_o), 32'(8'h50));
        bus.req_valid_i = 2'b00;
        tick;
        tick;
        check_eq("mid_rst_done", 32'(bus.req_done_o), 32'(1));
        tick;

        // Randomized traffic against the transaction-level model
        preset_i = 1'b1;
        tick;
        preset_i = 1'b0;
        last_m     = 1'b1;
        rdata_m    = 8'h00;
        cur_g      = 1'b0;
        cur_wr     = 1'b0;
        cur_addr   = 8'h00;
        cur_wdata  = 8'h00;
        waits_left = 0;
        for (int c = 0; c < 3000; c++) begin
            s_v = bus.req_valid_i;  s_wr = bus.req_write_i;
            s_addr = bus.req_addr_i; s_wdata = bus.req_wdata_i;
            s_psel = bus.psel_o; s_pen = bus.penable_o;
            s_ready = bus.pready_i; s_done = bus.req_done_o;
            tick;
            exp_done = 2'b00;
            if (!s_psel) begin
                elig = s_v & ~s_done;
                if (elig != 2'b00) begin
                    cur_g      = (elig == 2'b11) ? ~last_m : elig[1];
                    gi         = cur_g ? 1 : 0;
                    cur_addr   = s_addr[gi*8 +: 8];
                    cur_wdata  = s_wdata[gi*8 +: 8];
                    cur_wr     = s_wr[gi];
                    waits_left = int'($urandom_range(0, 3));
                    check_eq("r_grant", 32'({bus.psel_o, bus.penable_o, bus.paddr_o, bus.pwrite_o}),
                             32'({2'b10, cur_addr, cur_wr}));
                    if (cur_wr) check_eq("r_pwdata", 32'(bus.pwdata_o), 32'(cur_wdata));
                end else begin
                    check_eq("r_idle", 32'({bus.psel_o, bus.penable_o}), 32'(0));
                end
            end else if (!s_pen) begin
                check_eq("r_setup", 32'({bus.psel_o, bus.penable_o, bus.paddr_o}), 32'({2'b11, cur_addr}));
            end else if (s_ready) begin
                check_eq("r_end", 32'({bus.psel_o, bus.penable_o}), 32'(0));
                exp_done = cur_g ? 2'b10 : 2'b01;
                last_m   = cur_g;
                if (cur_wr) mem[cur_addr] = cur_wdata;
                else        rdata_m = mem[cur_addr];
            end else begin
                check_eq("r_hold", 32'({bus.psel_o, bus.penable_o, bus.paddr_o, bus.pwrite_o}),
                         32'({2'b11, cur_addr, cur_wr}));
            end
            check_eq("r_done", 32'(bus.req_done_o), 32'(exp_done));
            check_eq("r_rdata", 32'(bus.rdata_o), 32'(rdata_m));
            check_eq("r_err", 32'(bus.err_o), 32'(0));

            if (bus.psel_o && bus.penable_o) begin
                if (waits_left == 0) begin
                    bus.pready_i = 1'b1;
                    bus.prdata_i = mem[bus.paddr_o];
                end else begin
                    bus.pready_i = 1'b0;
                    bus.prdata_i = 8'($urandom);
                    waits_left--;
                end
            end else begin
                bus.pready_i = 1'($urandom_range(0, 1));
                bus.prdata_i = 8'($urandom);
            end
            for (int n = 0; n < 2; n++) begin
                if (bus.psel_o && (cur_g == n[0])) begin
                    if ($urandom_range(0, 3) == 0) begin
                        new_fields(n);
                        bus.req_valid_i[n] = 1'($urandom_range(0, 1));
                    end
                end else if (bus.req_done_o[n]) begin
                    new_fields(n);
                    bus.req_valid_i[n] = 1'($urandom_range(0, 1));
                end else if (bus.req_valid_i[n]) begin
                    if ($urandom_range(0, 7) == 0) bus.req_valid_i[n] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    new_fields(n);
                    bus.req_valid_i[n] = 1'b1;
                end
            end
        end

        // Stalled slave
        bus.req_valid_i = 2'b00;
        bus.pready_i    = 1'b0;
        preset_i = 1'b1;
        tick;
        preset_i = 1'b0;
        rdata_m  = 8'h00;
        xfer(1, 1'b0, 8'h66, 8'h00, 0, 8'h77);
`ifdef APB_TIMEOUT_EN
        set_req(0, 1'b0, 8'h55, 8'h00);
        tick;
        bus.req_valid_i = 2'b00;
        tick;
        for (int w = 0; w < 3; w++) begin
            tick;
            check_eq("to_wait", 32'({bus.psel_o, bus.penable_o, bus.req_done_o, bus.err_o}), 32'(5'b11000));
        end
        tick;
        check_eq("to_abort", 32'({bus.psel_o, bus.penable_o, bus.req_done_o, bus.err_o}), 32'(5'b00011));
        check_eq("to_rdata", 32'(bus.rdata_o), 32'(0));
        tick;
        check_eq("to_err_clr", 32'({bus.req_done_o, bus.err_o}), 32'(0));

        set_req(0, 1'b0, 8'h56, 8'h00);
        tick;
        bus.req_valid_i = 2'b00;
        tick;
        for (int w = 0; w < 3; w++) tick;
        bus.pready_i = 1'b1;
        bus.prdata_i = 8'h99;
        tick;
        check_eq("to_ready_wins", 32'({bus.req_done_o, bus.err_o}), 32'(3'b010));
        check_eq("to_ready_rdata", 32'(bus.rdata_o), 32'(8'h99));
        bus.pready_i = 1'b0;
        tick;
`else
        set_req(0, 1'b0, 8'h55, 8'h00);
        tick;
        bus.req_valid_i = 2'b00;
        repeat (100) tick;
        check_eq("stall_hold", 32'({bus.psel_o, bus.penable_o, bus.req_done_o, bus.err_o}), 32'(5'b11000));
        check_eq("stall_rdata", 32'(bus.rdata_o), 32'(8'h77));
        preset_i = 1'b1;
        tick;
        preset_i = 1'b0;
        check_eq("stall_rst", 32'({bus.psel_o, bus.penable_o}), 32'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
